prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
Programmable integer clock divider producing a registered, glitch-free divided clock plus a single-cycle tick pulse in the source clock domain. It is the configurable front stage of the divider chain. It supplies divide-by-N clocks and matching clock-enable ticks to downstream logic. A new ratio can be loaded at run time and is applied only on a period boundary, so the output never carries a runt pulse.

Parameters:
WIDTH, 8, width of ratio registers and period counter
DEFAULT_RATIO, 4, ratio after reset; must be >= 2 and < 2**WIDTH

Ports:
clk  input  1  source clock; all state on posedge, plus negedge only under ODD_DUTY50_EN
reset  input  1  asynchronous, active-high reset
ratio_in  input  WIDTH  requested divide ratio N
ratio_load  input  1  one-cycle strobe; sample ratio_in
ratio_busy  output  1  a legal ratio is pending, not yet applied
ratio_ack  output  1  one-cycle pulse; pending ratio has just taken effect
ratio_err  output  1  one-cycle pulse; rejected load (ratio_in < 2)
cur_ratio  output  WIDTH  ratio currently in effect
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse marking each clk_out rising edge

Behaviour:
- Reset (async, any time, including mid-period): cnt=0, clk_out=0, tick=0, cur_ratio=DEFAULT_RATIO, pending cleared, ratio_busy=0, ratio_ack=0, ratio_err=0. FSM goes to IDLE.
- FSM states:
  - IDLE: entered by reset. Moves to RUN on the first posedge after reset deasserts.
  - RUN: free-running.
- Counter: cnt counts 0..N-1 and wraps to 0. N = cur_ratio.
- High count H = ceil(N/2). clk_out is registered from the next counter value, so clk_out=1 while cnt < H and 0 otherwise.
  - Even N: 50% duty.
  - Odd N: high for (N+1)/2 cycles, low for (N-1)/2 cycles.
- First posedge after reset release: cnt=0, clk_out=1, tick=1.
- tick=1 exactly in cycles where cnt==0 (RUN only). Tick period is N clk cycles.
- ratio_load with ratio_in >= 2:
  - ratio_in is latched into pending, and ratio_busy=1 from the next cycle.
  - A second load while busy overwrites pending (last write wins). There is no ack for the overwritten value.
- ratio_load with ratio_in < 2: ratio_err=1 the next cycle. Pending and ratio_busy are unchanged.
- Apply: at the edge where cnt wraps N-1 -> 0 with pending valid:
  - cur_ratio <= pending and ratio_busy <= 0.
  - ratio_ack=1 in the same cycle as that period's tick.
  - The new period uses the new N and H from cnt=0.
- Load coinciding with a wrap edge: the wrap applies the old pending (if any). The new value becomes pending and applies at the next wrap.
- Loading ratio equal to cur_ratio: treated as a normal load, so busy and ack still occur.
- Counter width: cnt is WIDTH bits, with no overflow because N <= 2**WIDTH-1.

Optional Feature:
ODD_DUTY50_EN:
- Defined:
  - A posedge phase register p is high while cnt < (N-1)/2.
  - A negedge register n samples p.
  - For odd N, clk_out = p | n, giving exactly N/2 clk periods high (50% duty).
  - For even N, clk_out is unchanged from the base behaviour.
  - tick is unchanged.
  - Reset also clears n asynchronously.
- Undefined: no negedge logic is built, and odd N uses the ceil(N/2)-high duty described above.

Test Plan:
- Reset release, DEFAULT_RATIO=4 -> clk_out pattern 1100 repeating, tick every 4th cycle starting on the first posedge, cur_ratio=4.
- Load 6 mid-period -> ratio_busy=1 until the wrap; ratio_ack and tick coincide; then clk_out is 111000 repeating with no pulse shorter than 2 cycles at the switch.
- Load 5 then 3 before the wrap -> only 3 is applied, with a single ratio_ack; clk_out is 110 repeating (with ODD_DUTY50_EN: high 1.5 clk periods).
- Load 1 and load 0 -> ratio_err pulses one cycle each; cur_ratio, ratio_busy and clk_out cadence are unchanged.
- Load 7 at the exact wrap edge while 5 is pending -> 5 applies with ack; 7 applies at the following wrap with a second ack.
- Assert reset asynchronously mid-high-phase at N=6 -> clk_out, tick and busy go to 0 immediately without waiting for clk; after release the divider restarts at N=4 with the first-cycle tick.

Source files
------------

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: programmable integer clock divider with a registered divided
// clock, a source-domain tick per divided period, and run-time ratio reload that
// only takes effect on a period boundary so no runt pulse is ever emitted.
// Optional macro ODD_DUTY50_EN adds a negedge phase register giving 50% duty on odd ratios.
module prog_clk_divider #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ratio_in,
  input  logic             ratio_load,
  output logic             ratio_busy,
  output logic             ratio_ack,
  output logic             ratio_err,
  output logic [WIDTH-1:0] cur_ratio,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [WIDTH-1:0] DEF_R  = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             wrap;
  logic [WIDTH:0]   high_cnt;

  // Next-state: FSM, period counter, pending-ratio bookkeeping and output pre-decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    wrap       = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        wrap  = (cnt_q == (cur_q - ONE));
        cnt_d = wrap ? '0 : (cnt_q + ONE);
      end
      default: state_d = IDLE;
    endcase
    // A pending ratio is only swapped in at the wrap so the new period starts clean.
    if (wrap && pend_vld_q) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end
    // A load on the wrap edge lands after the swap above, so it waits for the next wrap.
    if (ratio_load && (ratio_in >= TWO)) begin
      pend_d     = ratio_in;
      pend_vld_d = 1'b1;
    end
    err_d    = ratio_load && (ratio_in < TWO);
    tick_d   = (cnt_d == '0);
    // High phase is ceil(N/2) counts; widened by one bit so N = 2**WIDTH-1 cannot overflow.
    high_cnt = ({1'b0, cur_d} + ONE_X) >> 1;
    clk_d    = ({1'b0, cnt_d} < high_cnt);
  end

  // State register; every output is a flop so clk_out and tick are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_q      <= DEF_R;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign ratio_busy = pend_vld_q;
  assign ratio_ack  = ack_q;
  assign ratio_err  = err_q;
  assign cur_ratio  = cur_q;
  assign tick       = tick_q;

`ifdef ODD_DUTY50_EN
  logic           p_q, p_d, n_q;
  logic [WIDTH:0] p_lim;

  // Posedge phase is high for (N-1)/2 counts; the half-cycle-late copy stretches it by 0.5.
  always_comb begin
    p_lim = ({1'b0, cur_d} - ONE_X) >> 1;
    p_d   = ({1'b0, cnt_d} < p_lim);
  end

  // Posedge phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_q <= 1'b0;
    else       p_q <= p_d;
  end

  // Negedge copy of the phase register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) n_q <= 1'b0;
    else       n_q <= p_q;
  end

  assign clk_out = cur_q[0] ? (p_q | n_q) : clk_q;
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: stimulus on the falling edge pushes the expected
// post-edge outputs into a queue; a monitor pops and compares just after each
// rising edge. Reference model tracks period phase, ratio and pending load as integers.
module tb_prog_clk_divider;

  logic       clk;
  logic       reset;
  logic [7:0] ratio_in;
  logic       ratio_load;
  logic       ratio_busy;
  logic       ratio_ack;
  logic       ratio_err;
  logic [7:0] cur_ratio;
  logic       clk_out;
  logic       tick;

  prog_clk_divider #(.WIDTH(8), .DEFAULT_RATIO(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ratio_in   (ratio_in),
    .ratio_load (ratio_load),
    .ratio_busy (ratio_busy),
    .ratio_ack  (ratio_ack),
    .ratio_err  (ratio_err),
    .cur_ratio  (cur_ratio),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  typedef struct packed {
    logic       clk;
    logic       tick;
    logic       busy;
    logic       ack;
    logic       err;
    logic [7:0] cur;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: running flag, phase within period, active N, pending ratio.
  int m_run, m_ph, m_n, m_pv, m_pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_ph   = 0;
    m_n    = 4;
    m_pv   = 0;
    m_pend = 0;
  endtask

  // Drive inputs for the coming rising edge and queue the outputs expected after it.
  task automatic drive_push(input logic ld, input logic [7:0] rin);
    exp_t e;
    int   wrap;
    int   ack;
    ratio_load = ld;
    ratio_in   = rin;
    wrap = (m_run == 1 && m_ph == m_n - 1) ? 1 : 0;
    if (m_run == 0) begin
      m_run = 1;
      m_ph  = 0;
    end else begin
      m_ph = (wrap != 0) ? 0 : m_ph + 1;
    end
    ack = (wrap != 0 && m_pv != 0) ? 1 : 0;
    if (ack != 0) begin
      m_n  = m_pend;
      m_pv = 0;
    end
    if (ld && rin >= 8'd2) begin
      m_pend = int'(rin);
      m_pv   = 1;
    end
    e.clk  = (m_ph < (m_n + 1) / 2);
    e.tick = (m_ph == 0);
    e.busy = (m_pv != 0);
    e.ack  = (ack != 0);
    e.err  = ld && (rin < 8'd2);
    e.cur  = 8'(m_n);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic ld, input logic [7:0] rin);
    @(negedge clk);
    drive_push(ld, rin);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_push(1'b0, 8'd0);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("clk_out",    int'(clk_out),    int'(e.clk));
        chk("tick",       int'(tick),       int'(e.tick));
        chk("ratio_busy", int'(ratio_busy), int'(e.busy));
        chk("ratio_ack",  int'(ratio_ack),  int'(e.ack));
        chk("ratio_err",  int'(ratio_err),  int'(e.err));
        chk("cur_ratio",  int'(cur_ratio),  int'(e.cur));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    ratio_in   = 8'd0;
    ratio_load = 1'b0;
    model_reset();
    #22;
    chk("rst_clk_out", int'(clk_out),    0);
    chk("rst_tick",    int'(tick),       0);
    chk("rst_busy",    int'(ratio_busy), 0);
    chk("rst_ack",     int'(ratio_ack),  0);
    chk("rst_err",     int'(ratio_err),  0);
    chk("rst_cur",     int'(cur_ratio),  4);

    // Default ratio: 1100 pattern.
    release_reset();
    repeat (12) step(1'b0, 8'd0);

    // Load 6 mid-period.
    for (int k = 0; k < 16 && m_ph != 1; k++) step(1'b0, 8'd0);
    step(1'b1, 8'd6);
    repeat (20) step(1'b0, 8'd0);

    // Load 5 then 3 inside one period: only 3 applies.
    for (int k = 0; k < 16 && m_ph != 0; k++) step(1'b0, 8'd0);
    step(1'b1, 8'd5);
    step(1'b1, 8'd3);
    repeat (15) step(1'b0, 8'd0);

    // Illegal ratios.
    step(1'b1, 8'd1);
    step(1'b0, 8'd0);
    step(1'b1, 8'd0);
    repeat (8) step(1'b0, 8'd0);

    // Load 7 exactly on the wrap edge while 5 is pending.
    for (int k = 0; k < 16 && m_ph != 0; k++) step(1'b0, 8'd0);
    step(1'b1, 8'd5);
    for (int k = 0; k < 16 && m_ph != m_n - 1; k++) step(1'b0, 8'd0);
    step(1'b1, 8'd7);
    repeat (20) step(1'b0, 8'd0);

    // Random loads, including illegal and same-as-current ratios.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, 8'($urandom_range(0, 12)));
      else                           step(1'b0, 8'd0);
    end

    // Async reset mid-high-phase at N=6 with a load pending.
    step(1'b1, 8'd6);
    for (int k = 0; k < 64 && !(m_n == 6 && m_ph == 0); k++) step(1'b0, 8'd0);
    step(1'b1, 8'd8);
    @(posedge clk);
    #3;
    chk("pre_arst_clk_out", int'(clk_out),    1);
    chk("pre_arst_busy",    int'(ratio_busy), 1);
    chk("pre_arst_cur",     int'(cur_ratio),  6);
    reset = 1'b1;
    #1;
    chk("arst_clk_out", int'(clk_out),    0);
    chk("arst_tick",    int'(tick),       0);
    chk("arst_busy",    int'(ratio_busy), 0);
    chk("arst_cur",     int'(cur_ratio),  4);
    release_reset();
    repeat (12) step(1'b0, 8'd0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
